// File: rtl/mic_control.sv
// I2S capture controller for the line-in ADC: generates MCLK/SCK/LRCK from a free-running
// 9-bit divider, deserialises both channels and hands each pair over with valid/ack and sticky overrun.
module mic_control #(
  parameter int DATA_WIDTH  = 16,
  parameter int SKIP_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  audio_sdout,
  input  logic                  sample_ack,
  input  logic                  overrun_clr,
  output logic                  audio_mclk,
  output logic                  audio_lrck,
  output logic                  audio_sck,
  output logic [DATA_WIDTH-1:0] audio_out_left,
  output logic [DATA_WIDTH-1:0] audio_out_right,
  output logic                  sample_valid,
  output logic                  overrun
);

  localparam logic [4:0] LAST_SLOT = 5'(DATA_WIDTH);
  localparam logic [3:0] SKIP_N    = 4'(SKIP_FRAMES);

  logic [8:0]            clk_cnt_q, clk_cnt_d;
  logic [3:0]            skip_q, skip_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] out_l_q, out_l_d;
  logic [DATA_WIDTH-1:0] out_r_q, out_r_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic [4:0]            slot;
  logic                  sample_en, in_window, last_slot;
  logic                  left_done, right_done, skip_done;
  logic [DATA_WIDTH-1:0] word;

  // Sample mid SCK-high: the ADC only moves its data on the SCK falling edge.
  assign sample_en  = (clk_cnt_q[2:0] == 3'b101);
  assign slot       = clk_cnt_q[7:3];
  assign in_window  = sample_en && (slot != 5'd0) && (slot <= LAST_SLOT);
  assign last_slot  = sample_en && (slot == LAST_SLOT);
  assign skip_done  = (skip_q == SKIP_N);
  assign left_done  = last_slot && !clk_cnt_q[8];
  assign right_done = last_slot && clk_cnt_q[8] && skip_done;

  // Word as it stands once the bit on the line is shifted in; only the newest DATA_WIDTH bits matter.
  assign word = DATA_WIDTH'({shift_q, audio_sdout});

  always_comb begin
    clk_cnt_d = clk_cnt_q + 9'd1;
    skip_d    = skip_q;
    shift_d   = shift_q;
    left_d    = left_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;

    if (clk_cnt_q == 9'd511 && !skip_done)
      skip_d = skip_q + 4'd1;

    if (in_window)
      shift_d = word;
    if (left_done)
      left_d = word;
    if (right_done) begin
      out_l_d = left_q;
      out_r_d = word;
    end

    // A completion coinciding with an ack keeps valid high for the fresh pair.
    if (right_done)
      valid_d = 1'b1;
    else if (sample_ack)
      valid_d = 1'b0;

    if (right_done && valid_q && !sample_ack)
      ovr_d = 1'b1;
    else if (overrun_clr)
      ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_cnt_q <= '0;
      skip_q    <= '0;
      shift_q   <= '0;
      left_q    <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      skip_q    <= skip_d;
      shift_q   <= shift_d;
      left_q    <= left_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign audio_mclk      = clk_cnt_q[1];
  assign audio_sck       = clk_cnt_q[2];
  assign audio_lrck      = clk_cnt_q[8];
  assign audio_out_left  = out_l_q;
  assign audio_out_right = out_r_q;
  assign sample_valid    = valid_q;
  assign overrun         = ovr_q;

endmodule

// File: doc/mic_control.md
Name: mic_control

Overview:
- I2S receive-side controller for the line-in ADC. It is the capture counterpart of the speaker path.
- Generates MCLK, LRCK and SCK with the same divider ratios the speaker path uses, so both converters can share one frame timing.
- Deserialises the ADC serial output into parallel left and right samples.
- Presents each sample pair to downstream audio logic through a valid/ack handshake, with sticky overrun detection.

Parameters:
- DATA_WIDTH, 16, number of MSBs captured per channel; legal range 1..24. ADC bits beyond this width are ignored.
- SKIP_FRAMES, 4, number of whole LRCK frames discarded after reset while the ADC settles; legal range 0..15.

Ports:
- clk  input  1  system clock from the crystal.
- rst  input  1  asynchronous, active-low reset.
- audio_sdout  input  1  serial data from the ADC.
- sample_ack  input  1  consumer acknowledge; clears sample_valid.
- overrun_clr  input  1  clears the sticky overrun flag.
- audio_mclk  output  1  master clock, clk/4.
- audio_lrck  output  1  word-select clock, clk/512; 0 = left, 1 = right.
- audio_sck  output  1  serial clock, clk/8 (32 SCK per channel).
- audio_out_left  output  DATA_WIDTH  last completed left sample, two's complement.
- audio_out_right  output  DATA_WIDTH  last completed right sample.
- sample_valid  output  1  a new sample pair is held and not yet acknowledged.
- overrun  output  1  sticky flag: a pair was overwritten before it was acknowledged.

Behaviour:
- Reset (rst=0, asynchronous): the following all go to 0 immediately.
  - 9-bit clk_cnt, skip counter, shift register, left hold register.
  - All outputs.
- Divider: clk_cnt increments every clk and wraps 511->0.
  - audio_mclk = clk_cnt[1]; audio_sck = clk_cnt[2]; audio_lrck = clk_cnt[8].
- Slot index = clk_cnt[7:3] (0..31) within each half-frame.
- I2S format: MSB occupies slot 1. Slot 0 is the one-SCK delay after the LRCK edge and is ignored.
- Sampling point: audio_sdout is sampled on the clk edge that ends the cycle with clk_cnt[2:0]==3'b101, i.e. mid SCK-high. The ADC changes data on SCK fall.
- Capture window: slots 1..DATA_WIDTH only.
  - Each sample shifts the shift register left, with the new bit entering at the LSB.
  - Slots 0 and DATA_WIDTH+1..31 do not touch the shift register.
- Left completion, at the sampling edge of slot DATA_WIDTH with lrck=0: the left hold register takes {shift[DATA_WIDTH-2:0], audio_sdout}.
- Right completion, at the sampling edge of slot DATA_WIDTH with lrck=1, and only if skip counter == SKIP_FRAMES:
  - audio_out_left <= left hold register.
  - audio_out_right <= {shift[DATA_WIDTH-2:0], audio_sdout}.
  - sample_valid <= 1.
  - Timing: outputs are visible in the cycle where clk_cnt == 256 + 8*DATA_WIDTH + 6 (390 for width 16).
- Skip counter:
  - Increments on each clk_cnt wrap 511->0 and saturates at SKIP_FRAMES.
  - Frames 0..SKIP_FRAMES-1 after reset produce no output update.
  - SKIP_FRAMES=0 means the first frame is delivered.
- Handshake:
  - sample_ack=1 while sample_valid=1 clears sample_valid on the next edge.
  - sample_ack while sample_valid=0 has no effect.
- Simultaneous right completion and ack: the data updates, sample_valid stays 1, and overrun is not set.
- Overrun: right completion while sample_valid=1 and sample_ack=0 sets overrun=1. The data is still overwritten with the newer pair.
- overrun_clr: clears overrun on the next edge. If a new overrun event occurs in the same cycle, the set wins.
- Mid-operation reset: an asynchronous reset at any point discards partial samples and restarts the divider at 0 and the skip count at 0. Divider phase is identical to the speaker path after a common reset.

Test Plan:
1. Hold rst=0, toggle audio_sdout -> all outputs 0. After release, audio_sck toggles every 4 clk, audio_lrck every 256 clk, audio_mclk every 2 clk.
2. Defaults; drive I2S left=16'hA5C3, right=16'h3C5A every frame, with 24-bit ADC LSBs = 8'hFF and slot 0 = 1 -> no sample_valid before absolute cycle 2438. In cycle 2438: sample_valid=1, audio_out_left=16'hA5C3, audio_out_right=16'h3C5A.
3. Never ack across two delivered frames (second frame left=16'h0001, right=16'hFFFF) -> overrun=1, outputs 16'h0001/16'hFFFF. sample_ack then clears sample_valid, overrun stays 1. overrun_clr returns overrun to 0.
4. Assert sample_ack exactly in the right-completion cycle (clk_cnt==389) with sample_valid=1 -> sample_valid remains 1, data updated, overrun remains 0.
5. DATA_WIDTH=8, SKIP_FRAMES=0; drive left=8'h81, right=8'h7E -> sample_valid first rises at clk_cnt==326 of frame 0 with these values.
6. Assert reset during right slot 8 of a delivered frame -> outputs 0 asynchronously. After release, no valid for 4 frames, then correct data.
